keypad_scan_ctrl: RTL

//   Sequences column scanning of the 4x4 keypad: drives one column low at a

---
 rtl/keypad_scan_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-low keypad one column at a time, samples the rows once
// per column after a settle delay, classifies each full sweep and debounces
// the result over whole sweeps before publishing a hex key code.
module keypad_scan_ctrl #(
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE_TICKS   = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_TICKS);
  localparam int NW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] SAMPLE_AT  = CW'(SETTLE_TICKS - 1);
  localparam logic [NW-1:0] CNT_ONE    = NW'(1);
  localparam logic [NW-1:0] CNT_DONE   = NW'(DEBOUNCE_SCANS);
  localparam bit            SINGLE     = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  // Map a (column, row) position to the printed key legend.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] v;
    case ({c, r})
      4'b00_00: v = 4'h1;
      4'b00_01: v = 4'h4;
      4'b00_10: v = 4'h7;
      4'b00_11: v = 4'h0;
      4'b01_00: v = 4'h2;
      4'b01_01: v = 4'h5;
      4'b01_10: v = 4'h8;
      4'b01_11: v = 4'hF;
      4'b10_00: v = 4'h3;
      4'b10_01: v = 4'h6;
      4'b10_10: v = 4'h9;
      4'b10_11: v = 4'hE;
      4'b11_00: v = 4'hA;
      4'b11_01: v = 4'hB;
      4'b11_10: v = 4'hC;
      default:  v = 4'hD;
    endcase
    return v;
  endfunction

  logic [CW-1:0]      r_dwell;
  logic [1:0]         r_col_idx;
  logic [3:0][3:0]    r_samp;
  state_t             r_state;
  logic [NW-1:0]      r_cnt;
  logic [3:0]         r_cand;
  logic [3:0]         r_key_code;
  logic               r_key_valid;

  state_t             w_state_nxt;
  logic [NW-1:0]      w_cnt_nxt;
  logic [NW-1:0]      w_cnt_inc;
  logic [3:0]         w_cand_nxt;
  logic               w_accept;
  logic               w_dwell_wrap;
  logic               w_sample;
  logic               w_sweep_end;
  logic [4:0]         w_zeros;
  logic [3:0]         w_code;
  logic               w_none;
  logic               w_one;

  assign w_dwell_wrap = (r_dwell == DWELL_LAST);
  assign w_sample     = (r_dwell == SAMPLE_AT);
  assign w_sweep_end  = w_dwell_wrap && (r_col_idx == 2'd3);
  assign w_cnt_inc    = r_cnt + CNT_ONE;

  // Dwell counter and column index; column advances as the dwell wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
    end else if (w_dwell_wrap) begin
      r_dwell   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_dwell   <= r_dwell + CW'(1);
    end
  end

  // Capture the row lines for the active column once the lines have settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_samp <= {4{4'hF}};
    end else if (w_sample) begin
      r_samp[r_col_idx] <= row;
    end
  end

  // Classify the completed sweep: count pressed positions, remember the code.
  always_comb begin
    w_zeros = '0;
    w_code  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!r_samp[2'(c)][2'(3 - r)]) begin
          w_zeros = w_zeros + 5'd1;
          w_code  = key_map(2'(c), 2'(r));
        end
      end
    end
  end

  assign w_none = (w_zeros == 5'd0);
  assign w_one  = (w_zeros == 5'd1);

  // Debounce state register with its sweep counter and candidate code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Debounce next-state logic, evaluated only at the end of each sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (w_sweep_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_one) begin
            w_cand_nxt = w_code;
            if (SINGLE) begin
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = S_PRESS_CHK;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        S_PRESS_CHK: begin
          if (w_one) begin
            if (w_code == r_cand) begin
              if (w_cnt_inc == CNT_DONE) begin
                w_state_nxt = S_HELD;
                w_cnt_nxt   = '0;
                w_accept    = 1'b1;
              end else begin
                w_cnt_nxt   = w_cnt_inc;
              end
            end else begin
              // A different single key restarts the count on the new code.
              w_cand_nxt = w_code;
              w_cnt_nxt  = CNT_ONE;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_HELD: begin
          // Ghosting or a second key while held does not end the press.
          if (w_none) begin
            if (SINGLE) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_RELEASE_CHK;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        default: begin
          if (w_none) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  // Publish the accepted code and a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= w_code;
      end
    end
  end

  // Output decode: column drive and held flag derive from registered state.
  always_comb begin
    col       = ~(4'b1000 >> r_col_idx);
    key_code  = r_key_code;
    key_valid = r_key_valid;
    key_held  = (r_state == S_HELD) || (r_state == S_RELEASE_CHK);
  end

endmodule
